// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares the instruction_cache read port between fetch (F) and debug (D).
// Define IMEM_ARB_PERF_EN to build the per-port grant counters.
module imem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          f_req_valid,
  input  logic [AW-1:0] f_req_addr,
  output logic          f_req_ready,
  output logic          f_rsp_valid,
  output logic [DW-1:0] f_rsp_data,
  output logic          f_rsp_err,
  input  logic          f_rsp_ready,
  input  logic          d_req_valid,
  input  logic [AW-1:0] d_req_addr,
  output logic          d_req_ready,
  output logic          d_rsp_valid,
  output logic [DW-1:0] d_rsp_data,
  output logic          d_rsp_err,
  input  logic          d_rsp_ready,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_data,
  output logic [31:0]   f_grant_cnt,
  output logic [31:0]   d_grant_cnt
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

  typedef enum logic {IDLE, RESP} state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic [DW-1:0] data_q, data_d;
  logic          err_q, err_d;
  logic [SW-1:0] starve_q, starve_d;

  logic hs, eligible, win_d;
  logic f_acc, d_acc, mis;

  // Arbitration: a slot opens when idle or when the held response drains.
  always_comb begin
    hs = (state_q == RESP) &&
         (owner_q ? d_rsp_ready : f_rsp_ready);
    eligible = !reset && ((state_q == IDLE) || hs);
    win_d = d_req_valid &&
            (!f_req_valid || (starve_q >= LIM));
    f_req_ready = eligible && !win_d;
    d_req_ready = eligible && win_d;
    mem_addr = (eligible && win_d) ? d_req_addr : f_req_addr;
    f_acc = f_req_valid && f_req_ready;
    d_acc = d_req_valid && d_req_ready;
    mis = (mem_addr[1:0] != 2'b00);
  end

  // Next state: capture on accept, drop to idle on a plain drain.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    data_d   = data_q;
    err_d    = err_q;
    starve_d = starve_q;
    if (f_acc || d_acc) begin
      state_d = RESP;
      owner_d = d_acc;
      err_d   = mis;
      data_d  = mis ? '0 : mem_data;
    end else if (hs) begin
      state_d = IDLE;
    end
    if (d_acc) begin
      starve_d = '0;
    end else if (eligible && d_req_valid && (starve_q < LIM)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // State and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      data_q   <= '0;
      err_q    <= 1'b0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      data_q   <= data_d;
      err_q    <= err_d;
      starve_q <= starve_d;
    end
  end

  // Response fan-out: only the owner sees the held response.
  always_comb begin
    f_rsp_valid = (state_q == RESP) && !owner_q;
    d_rsp_valid = (state_q == RESP) && owner_q;
    f_rsp_data  = owner_q ? '0 : data_q;
    f_rsp_err   = owner_q ? 1'b0 : err_q;
    d_rsp_data  = owner_q ? data_q : '0;
    d_rsp_err   = owner_q ? err_q : 1'b0;
  end

`ifdef IMEM_ARB_PERF_EN
  logic [31:0] f_cnt_q, d_cnt_q;

  // Grant counters, wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      f_cnt_q <= '0;
      d_cnt_q <= '0;
    end else begin
      if (f_acc) f_cnt_q <= f_cnt_q + 32'd1;
      if (d_acc) d_cnt_q <= d_cnt_q + 32'd1;
    end
  end

  assign f_grant_cnt = f_cnt_q;
  assign d_grant_cnt = d_cnt_q;
`else
  assign f_grant_cnt = '0;
  assign d_grant_cnt = '0;
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb_imem_port_arbiter: directed and random checks of imem_port_arbiter
// against a pending-response reference model.
module tb_imem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LIM = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          f_req_valid, f_req_ready, f_rsp_valid, f_rsp_err, f_rsp_ready;
  logic          d_req_valid, d_req_ready, d_rsp_valid, d_rsp_err, d_rsp_ready;
  logic [AW-1:0] f_req_addr, d_req_addr, mem_addr;
  logic [DW-1:0] f_rsp_data, d_rsp_data, mem_data;
  logic [31:0]   f_grant_cnt, d_grant_cnt;

  logic [31:0] rom [0:63];
  assign mem_data = rom[mem_addr[7:2]];

  imem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .f_req_valid(f_req_valid), .f_req_addr(f_req_addr),
    .f_req_ready(f_req_ready), .f_rsp_valid(f_rsp_valid),
    .f_rsp_data(f_rsp_data), .f_rsp_err(f_rsp_err),
    .f_rsp_ready(f_rsp_ready),
    .d_req_valid(d_req_valid), .d_req_addr(d_req_addr),
    .d_req_ready(d_req_ready), .d_rsp_valid(d_rsp_valid),
    .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
    .d_rsp_ready(d_rsp_ready),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .f_grant_cnt(f_grant_cnt), .d_grant_cnt(d_grant_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: at most one pending response.
  bit          pv;
  bit          po;
  logic [31:0] pd;
  bit          pe;
  int          starve;
  int unsigned fcnt, dcnt;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pv = 0; po = 0; pd = '0; pe = 0;
    starve = 0; fcnt = 0; dcnt = 0;
  endtask

  task automatic step(input logic fv, input logic [31:0] fa,
                      input logic fr, input logic dv,
                      input logic [31:0] da, input logic dr,
                      output bit fgo, output bit dgo);
    bit hs, can, wd;
    logic [31:0] a;
    f_req_valid = fv; f_req_addr = fa; f_rsp_ready = fr;
    d_req_valid = dv; d_req_addr = da; d_rsp_ready = dr;
    #1;
    hs  = pv && (po ? dr : fr);
    can = !pv || hs;
    wd  = dv && (!fv || starve >= LIM);
    chk("f_req_ready", f_req_ready, can && !wd);
    chk("d_req_ready", d_req_ready, can && wd);
    chk("mem_addr", mem_addr, (can && wd) ? da : fa);
    chk("f_rsp_valid", f_rsp_valid, pv && !po);
    chk("d_rsp_valid", d_rsp_valid, pv && po);
    if (pv && !po) begin
      chk("f_rsp_data", f_rsp_data, pd);
      chk("f_rsp_err", f_rsp_err, pe);
      chk("d_rsp_data_idle", d_rsp_data, 0);
      chk("d_rsp_err_idle", d_rsp_err, 0);
    end
    if (pv && po) begin
      chk("d_rsp_data", d_rsp_data, pd);
      chk("d_rsp_err", d_rsp_err, pe);
      chk("f_rsp_data_idle", f_rsp_data, 0);
      chk("f_rsp_err_idle", f_rsp_err, 0);
    end
    fgo = can && !wd && fv;
    dgo = can && wd;
    if (fgo || dgo) begin
      a  = dgo ? da : fa;
      pv = 1;
      po = dgo;
      pe = (a[1:0] != 2'b00);
      pd = pe ? 32'h0 : rom[a[7:2]];
      if (dgo) begin
        dcnt++;
        starve = 0;
      end else begin
        fcnt++;
        if (dv && starve < LIM) starve++;
      end
    end else if (hs) begin
      pv = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_f_req_ready", f_req_ready, 0);
    chk("rst_d_req_ready", d_req_ready, 0);
    @(negedge clk);
    model_reset();
    chk("rst_f_rsp_valid", f_rsp_valid, 0);
    chk("rst_d_rsp_valid", d_rsp_valid, 0);
    chk("rst_f_cnt", f_grant_cnt, 0);
    chk("rst_d_cnt", d_grant_cnt, 0);
    reset = 1'b0;
  endtask

  task automatic chk_cnt(input string tag);
`ifdef IMEM_ARB_PERF_EN
    chk({tag, "_f_cnt"}, f_grant_cnt, fcnt);
    chk({tag, "_d_cnt"}, d_grant_cnt, dcnt);
`else
    chk({tag, "_f_cnt"}, f_grant_cnt, 0);
    chk({tag, "_d_cnt"}, d_grant_cnt, 0);
`endif
  endtask

  initial begin
    bit fg, dg;
    logic [9:0] gr;
    logic [31:0] fa, da;

    for (int i = 0; i < 64; i++)
      rom[i] = (32'(i) * 32'h9E3779B1) ^ 32'h13;
    rom[0]  = 32'h01901337;
    rom[3]  = 32'h0023E233;
    rom[5]  = 32'h004282B3;
    rom[18] = 32'h00910133;

    reset = 1'b1;
    f_req_valid = 0; f_req_addr = '0; f_rsp_ready = 0;
    d_req_valid = 0; d_req_addr = '0; d_rsp_ready = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    // F-only back-to-back
    step(1, 32'h00, 1, 0, 0, 1, fg, dg);
    chk("t1_data0", f_rsp_data, 32'h01901337);
    step(1, 32'h48, 1, 0, 0, 1, fg, dg);
    chk("t1_valid1", f_rsp_valid, 1);
    chk("t1_data1", f_rsp_data, 32'h00910133);
    step(0, 32'h00, 1, 0, 0, 1, fg, dg);

    // Both valid: starvation rotation
    gr = '0;
    for (int i = 0; i < 10; i++) begin
      step(1, 32'(4 * i), 1, 1, 32'h14, 1, fg, dg);
      gr[i] = d_rsp_valid;
      if (d_rsp_valid)
        chk("t2_d_data", d_rsp_data, 32'h004282B3);
    end
    chk("t2_order", gr, 10'h210);
    step(0, 0, 1, 0, 0, 1, fg, dg);

    // Misaligned fetch
    step(1, 32'h06, 1, 0, 0, 1, fg, dg);
    chk("t3_err", f_rsp_err, 1);
    chk("t3_data", f_rsp_data, 0);
    step(0, 0, 1, 0, 0, 1, fg, dg);

    // D backpressure blocks F
    step(0, 0, 1, 1, 32'h14, 0, fg, dg);
    for (int i = 0; i < 5; i++) begin
      step(1, 32'h0C, 1, 0, 0, 0, fg, dg);
      chk("t4_d_hold", d_rsp_data, 32'h004282B3);
    end
    step(1, 32'h0C, 1, 0, 0, 1, fg, dg);
    chk("t4_f_acc", f_rsp_valid, 1);
    chk("t4_f_data", f_rsp_data, 32'h0023E233);
    step(0, 0, 1, 0, 0, 1, fg, dg);

    // Reset mid-response with starvation built up
    step(1, 32'h00, 1, 1, 32'h14, 1, fg, dg);
    step(1, 32'h04, 1, 1, 32'h14, 1, fg, dg);
    step(1, 32'h08, 0, 1, 32'h14, 0, fg, dg);
    step(1, 32'h08, 0, 1, 32'h14, 0, fg, dg);
    do_reset();
    for (int i = 0; i < 4; i++)
      step(1, 32'h0C, 1, 1, 32'h14, 1, fg, dg);
    step(1, 32'h0C, 1, 0, 0, 1, fg, dg);
    chk("t5_data", f_rsp_data, 32'h0023E233);
    step(0, 0, 1, 0, 0, 1, fg, dg);

    // Grant counters: 3 F and 2 D
    do_reset();
    step(1, 32'h00, 1, 0, 0, 1, fg, dg);
    step(0, 0, 1, 1, 32'h14, 1, fg, dg);
    step(1, 32'h48, 1, 0, 0, 1, fg, dg);
    step(0, 0, 1, 1, 32'h10, 1, fg, dg);
    step(1, 32'h0C, 1, 0, 0, 1, fg, dg);
    step(0, 0, 1, 0, 0, 1, fg, dg);
    chk_cnt("t6");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      fa = $urandom;
      da = $urandom;
      if ($urandom_range(3) != 0) fa[1:0] = 2'b00;
      if ($urandom_range(3) != 0) da[1:0] = 2'b00;
      step($urandom_range(3) != 0, fa, $urandom_range(9) < 7,
           $urandom_range(2) != 0, da, $urandom_range(9) < 7,
           fg, dg);
    end
    chk_cnt("rand");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
